// File: rtl/team_05_arb_pkg.sv
// Shared types and widths for the team_05 Wishbone master arbiter.
package team_05_arb_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, BUS = 1'b1} state_t;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // Index width for a requester count; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/team_05_rr_picker.sv
// Combinational round-robin picker: search starts one past the last grant.
module team_05_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_gnt,
  output logic               any_req,
  output logic [IDX_W-1:0]   winner,
  output logic [NUM_REQ-1:0] onehot
);
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    onehot  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any_req && req[j] && (((int'(last_gnt) + i) % NUM_REQ) == j)) begin
          any_req   = 1'b1;
          winner    = IDX_W'(j);
          onehot[j] = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/team_05_wbm_arbiter.sv
// Round-robin sharing of the team_05 classic-cycle Wishbone master port,
// with registered outputs, read-data return and timeout abort.
module team_05_wbm_arbiter
  import team_05_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ*32-1:0]   req_adr_i,
  input  logic [NUM_REQ*32-1:0]   req_dat_i,
  input  logic [NUM_REQ*4-1:0]    req_sel_i,
  input  logic [NUM_REQ-1:0]      req_we_i,
  output logic [NUM_REQ-1:0]      req_gnt_o,
  output logic [NUM_REQ-1:0]      req_ack_o,
  output logic [NUM_REQ-1:0]      req_err_o,
  output logic [WB_DAT_W-1:0]     req_rdata_o,
  output logic                    busy_o,
  output logic [WB_ADR_W-1:0]     ADR_O,
  output logic [WB_DAT_W-1:0]     DAT_O,
  output logic [WB_SEL_W-1:0]     SEL_O,
  output logic                    WE_O,
  output logic                    STB_O,
  output logic                    CYC_O,
  input  logic [WB_DAT_W-1:0]     DAT_I,
  input  logic                    ACK_I
);
  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int LANES = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t             state;
  logic [IDX_W-1:0]   last_gnt;
  logic [CNT_W-1:0]   cnt;
  logic               any_req;
  logic [IDX_W-1:0]   win;
  logic [NUM_REQ-1:0] win_onehot;
  logic               timeout_hit;

  // Lanes padded to a power of two with zeros so the winner index never
  // selects undriven bits.
  logic [WB_ADR_W-1:0] lane_adr [LANES];
  logic [WB_DAT_W-1:0] lane_dat [LANES];
  logic [WB_SEL_W-1:0] lane_sel [LANES];
  logic                lane_we  [LANES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    if (k < NUM_REQ) begin : g_used
      assign lane_adr[k] = req_adr_i[32*k +: 32];
      assign lane_dat[k] = req_dat_i[32*k +: 32];
      assign lane_sel[k] = req_sel_i[4*k +: 4];
      assign lane_we[k]  = req_we_i[k];
    end else begin : g_pad
      assign lane_adr[k] = '0;
      assign lane_dat[k] = '0;
      assign lane_sel[k] = '0;
      assign lane_we[k]  = 1'b0;
    end
  end

  team_05_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req      (req_i),
    .last_gnt (last_gnt),
    .any_req  (any_req),
    .winner   (win),
    .onehot   (win_onehot)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      last_gnt    <= IDX_W'(NUM_REQ - 1);
      cnt         <= '0;
      req_gnt_o   <= '0;
      req_ack_o   <= '0;
      req_err_o   <= '0;
      req_rdata_o <= '0;
      busy_o      <= 1'b0;
      ADR_O       <= '0;
      DAT_O       <= '0;
      SEL_O       <= '0;
      WE_O        <= 1'b0;
      STB_O       <= 1'b0;
      CYC_O       <= 1'b0;
    end else begin
      req_ack_o <= '0;
      req_err_o <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            ADR_O     <= lane_adr[win];
            DAT_O     <= lane_dat[win];
            SEL_O     <= lane_sel[win];
            WE_O      <= lane_we[win];
            CYC_O     <= 1'b1;
            STB_O     <= 1'b1;
            busy_o    <= 1'b1;
            req_gnt_o <= win_onehot;
            last_gnt  <= win;
            cnt       <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          cnt <= cnt + 1'b1;
          // ACK takes priority over a timeout landing on the same cycle.
          if (ACK_I) begin
            req_rdata_o <= DAT_I;
            req_ack_o   <= req_gnt_o;
            CYC_O       <= 1'b0;
            STB_O       <= 1'b0;
            busy_o      <= 1'b0;
            req_gnt_o   <= '0;
            state       <= IDLE;
          end else if (timeout_hit) begin
            req_err_o <= req_gnt_o;
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            busy_o    <= 1'b0;
            req_gnt_o <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/team_05_wbm_arbiter.md
Name: team_05_wbm_arbiter

Overview:
Round-robin arbiter and sequencer for the team_05 Wishbone master port (ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O, DAT_I/ACK_I) toward the Nebula wishbone arbitrator.
- Shares the single classic-cycle master port between NUM_REQ internal requesters, e.g. a DMA engine and a frame/SRAM fetcher.
- Registers each transaction, waits for ACK_I, returns read data, and aborts on timeout.
- Sits inside the team_05 bus wrapper level, replacing the tied-off master outputs.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 255, cycles in BUS without ACK_I before abort; 0 disables timeout.
- CNT_W, 8, timeout counter width; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- req_i  in  NUM_REQ  per-requester request level.
- req_adr_i  in  NUM_REQ*32  request addresses, requester k at bits [32k+31:32k].
- req_dat_i  in  NUM_REQ*32  write data, same packing.
- req_sel_i  in  NUM_REQ*4  byte selects.
- req_we_i  in  NUM_REQ  1 = write.
- req_gnt_o  out  NUM_REQ  one-hot; high while that requester owns the bus.
- req_ack_o  out  NUM_REQ  one-cycle completion pulse.
- req_err_o  out  NUM_REQ  one-cycle timeout-abort pulse.
- req_rdata_o  out  32  read data; valid with req_ack_o, held until the next ACK.
- busy_o  out  1  high in BUS.
- ADR_O  out  32  Wishbone master address.
- DAT_O  out  32  Wishbone master write data.
- SEL_O  out  4  Wishbone master byte selects.
- WE_O  out  1  Wishbone master write enable.
- STB_O  out  1  Wishbone master strobe.
- CYC_O  out  1  Wishbone master cycle.
- DAT_I  in  32  Wishbone master read data.
- ACK_I  in  1  Wishbone master acknowledge.

Behaviour:
Reset and clocking:
- One clock, wb_clk_i; wb_rst_i is synchronous and active-high.
- All outputs are registered; reset value of every output is 0.
- Reset state: state=IDLE, last_gnt=NUM_REQ-1, so requester 0 wins first; timeout counter=0.

Arbitration:
- Combinational round-robin pick; search order starts at last_gnt+1 mod NUM_REQ.

State machine:
- IDLE:
  - If any req_i is high: latch the winner's adr/dat/sel/we into ADR_O/DAT_O/SEL_O/WE_O, set CYC_O=STB_O=1, set req_gnt_o[w], set last_gnt=w, clear counter, go to BUS.
  - Latency is 1 cycle from req_i high to CYC_O/STB_O high.
  - ACK_I seen in IDLE is ignored.
- BUS:
  - Hold all master outputs stable and increment the counter each cycle.
  - On ACK_I=1: capture DAT_I into req_rdata_o (writes also capture it), pulse req_ack_o[g], clear CYC_O/STB_O/req_gnt_o/busy_o, go to IDLE.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: pulse req_err_o[g], clear CYC_O/STB_O/req_gnt_o, leave req_rdata_o unchanged, go to IDLE.
  - If ACK_I and timeout coincide, ACK wins and no err pulse is issued.

Boundary conditions:
- IDLE always lasts at least one cycle between transactions, so CYC_O has a 1-cycle low gap.
- Requester protocol: hold req_i and its payload until ack/err. Requester deasserts req_i the cycle after its pulse; if it stays high it is re-queued and round-robin ordering applies.
- A requester dropping req_i mid-BUS is ignored; the transaction completes or times out normally.
- Only the lowest NUM_REQ bits of all arrays are used; no X-propagation from unused lanes.
- Reset mid-transaction: at that edge CYC_O/STB_O drop to 0, any pending ack/err is lost, and no pulse is emitted.

Decomposition:
- team_05_arb_pkg:
  - state_t enum {IDLE, BUS}.
  - localparams WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4.
- Sub-module team_05_rr_picker: combinational round-robin picker.
  - Inputs: req vector, last_gnt.
  - Outputs: any_req, winner index, one-hot vector.

Test Plan:
- Reset, then req_i=01, req_adr_i[0]=0x3000_0010, we=0; ACK_I on the 3rd BUS cycle with DAT_I=0xDEAD_BEEF:
  - CYC_O/STB_O high 1 cycle after req.
  - ADR_O=0x3000_0010.
  - req_ack_o=01 for one cycle.
  - req_rdata_o=0xDEAD_BEEF.
- req_i=11 held continuously, every transaction ACKed immediately:
  - Grants alternate 0,1,0,1.
  - Each CYC_O burst is 1 cycle wide with a 1-cycle low gap.
- Write from requester 1 (adr 0x3000_0020, dat 0x1234_5678, sel 0xF):
  - WE_O=1 and DAT_O/SEL_O match.
  - All outputs stable until ACK_I.
- TIMEOUT_CYCLES=4, ACK_I never asserted:
  - CYC_O high exactly 4 cycles.
  - req_err_o[0] pulses once, with no ack.
  - req_rdata_o unchanged.
- Test ACK_I coincident with the timeout cycle:
  - Only req_ack_o pulses.
- Test wb_rst_i asserted in the 2nd BUS cycle:
  - Next cycle all outputs are 0 and no ack/err pulse occurs.
  - After release, req_i=11 grants requester 0 first.
